// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache requests onto one RAM port.
// Data side wins by default; a saturating starvation counter forces an instruction grant.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              starved
);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     stateReg, stateNext;
  logic [3:0] starveCntReg, starveCntNext;
  logic       dReq;
  logic       atLimit;

  assign dReq    = dREN | dWEN;
  assign atLimit = (starveCntReg == LIMIT);
  assign starved = atLimit;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stateReg     <= ARB;
      starveCntReg <= 4'd0;
    end else begin
      stateReg     <= stateNext;
      starveCntReg <= starveCntNext;
    end
  end

  // Counter only counts cycles the instruction side is actually waiting outside its own grant.
  always_comb begin
    starveCntNext = starveCntReg;
    if (stateReg == IGRANT) begin
      if (iREN && ram_ready) starveCntNext = 4'd0;
    end else if (iREN && !atLimit) begin
      starveCntNext = starveCntReg + 4'd1;
    end
  end

  always_comb begin
    stateNext = stateReg;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    unique case (stateReg)
      ARB: begin
        if (dReq && !(iREN && atLimit)) stateNext = DGRANT;
        else if (iREN)                  stateNext = IGRANT;
      end
      DGRANT: begin
        ramaddr = daddr;
        if (!dReq) begin
          // Withdrawn request: no strobe, no completion, even if RAM reports ready.
          stateNext = ARB;
        end else begin
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          dwait = !ram_ready;
          if (ram_ready) begin
            if (!dWEN) dload = ramload;
            stateNext = ARB;
          end
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        if (!iREN) begin
          stateNext = ARB;
        end else begin
          ramREN = 1'b1;
          iwait  = !ram_ready;
          if (ram_ready) begin
            iload     = ramload;
            stateNext = ARB;
          end
        end
      end
      default: stateNext = ARB;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven per-cycle vectors for mem_arbiter with a queue scoreboard,
// plus a hand-written starvation/reset sequence.
module tb_mem_arbiter;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, starved;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .starved(starved)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic rst, iR, dR, dW;
    logic [31:0] ia, da, ds, rl;
    logic rdy;
    logic eRR, eRW;
    logic [31:0] eRA, eRS;
    logic eIW, eDW;
    logic [31:0] eIL, eDL;
    logic eST;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(logic rst, logic iR, logic dR, logic dW,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                              logic [31:0] rl, logic rdy,
                              logic eRR, logic eRW, logic [31:0] eRA, logic [31:0] eRS,
                              logic eIW, logic eDW, logic [31:0] eIL, logic [31:0] eDL,
                              logic eST);
    vec_t v;
    v.rst = rst; v.iR = iR; v.dR = dR; v.dW = dW;
    v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rdy = rdy;
    v.eRR = eRR; v.eRW = eRW; v.eRA = eRA; v.eRS = eRS;
    v.eIW = eIW; v.eDW = eDW; v.eIL = eIL; v.eDL = eDL; v.eST = eST;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    nRST = v.rst; iREN = v.iR; dREN = v.dR; dWEN = v.dW;
    iaddr = v.ia; daddr = v.da; dstore = v.ds; ramload = v.rl; ram_ready = v.rdy;
  endtask

  initial begin
    vec_t e;
    int firstStarved;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;

    //         rst iR dR dW  ia     da       ds   rl           rdy | RR RW  RA       RS  IW DW  IL           DL           ST
    vecs.push_back(mk(0, 0,0,0, 32'h0, 32'h0,    0, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 0 reset
    vecs.push_back(mk(1, 0,1,0, 32'h0, 32'h100,  0, 32'h11111111, 0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 1 ARB
    vecs.push_back(mk(1, 0,1,0, 32'h0, 32'h100,  0, 32'h11111111, 0,  1,0, 32'h100,  0,  1,1, 0,           0,           0)); // 2 DGRANT
    vecs.push_back(mk(1, 0,1,0, 32'h0, 32'h100,  0, 32'h11111111, 0,  1,0, 32'h100,  0,  1,1, 0,           0,           0)); // 3
    vecs.push_back(mk(1, 0,1,0, 32'h0, 32'h100,  0, 32'hDEADBEEF, 1,  1,0, 32'h100,  0,  1,0, 0,           32'hDEADBEEF,0)); // 4 done
    vecs.push_back(mk(1, 0,0,0, 32'h0, 32'h0,    0, 32'hDEADBEEF, 1,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 5 ARB
    vecs.push_back(mk(1, 0,0,1, 32'h0, 32'h3100, 5, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 6 write ARB
    vecs.push_back(mk(1, 0,0,1, 32'h0, 32'h3100, 5, 32'hAAAA5555, 1,  0,1, 32'h3100, 5,  1,0, 0,           0,           0)); // 7 write
    vecs.push_back(mk(1, 1,1,0, 32'h40,32'h200,  0, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 8 both
    vecs.push_back(mk(1, 1,1,0, 32'h40,32'h200,  0, 32'h12345678, 1,  1,0, 32'h200,  0,  1,0, 0,           32'h12345678,0)); // 9 D first
    vecs.push_back(mk(1, 1,0,0, 32'h40,32'h0,    0, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 10 ARB
    vecs.push_back(mk(1, 1,0,0, 32'h40,32'h0,    0, 32'hCAFEF00D, 1,  1,0, 32'h40,   0,  0,1, 32'hCAFEF00D,0,           0)); // 11 I
    vecs.push_back(mk(1, 0,0,0, 32'h0, 32'h0,    0, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 12 idle
    vecs.push_back(mk(1, 1,1,0, 32'h80,32'h300,  0, 32'h1,        1,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 13 cnt0
    vecs.push_back(mk(1, 1,1,0, 32'h80,32'h300,  0, 32'h1,        1,  1,0, 32'h300,  0,  1,0, 0,           32'h1,       0)); // 14 cnt1
    vecs.push_back(mk(1, 1,1,0, 32'h80,32'h300,  0, 32'h2,        1,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 15 cnt2
    vecs.push_back(mk(1, 1,1,0, 32'h80,32'h300,  0, 32'h2,        1,  1,0, 32'h300,  0,  1,0, 0,           32'h2,       0)); // 16 cnt3
    vecs.push_back(mk(1, 1,1,0, 32'h80,32'h300,  0, 32'h3,        1,  0,0, 32'h0,    0,  1,1, 0,           0,           1)); // 17 starved
    vecs.push_back(mk(1, 1,1,0, 32'h80,32'h300,  0, 32'h3,        1,  1,0, 32'h80,   0,  0,1, 32'h3,       0,           1)); // 18 I forced
    vecs.push_back(mk(1, 0,0,0, 32'h0, 32'h0,    0, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 19 cleared
    vecs.push_back(mk(1, 0,1,0, 32'h0, 32'h400,  0, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 20 ARB
    vecs.push_back(mk(1, 0,0,0, 32'h0, 32'h400,  0, 32'h77,       1,  0,0, 32'h400,  0,  1,1, 0,           0,           0)); // 21 withdraw
    vecs.push_back(mk(1, 0,0,0, 32'h0, 32'h400,  0, 32'h77,       0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 22 ARB
    vecs.push_back(mk(1, 1,0,0, 32'h500,32'h0,   0, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 23 ARB
    vecs.push_back(mk(1, 1,0,0, 32'h500,32'h0,   0, 32'h0,        0,  1,0, 32'h500,  0,  1,1, 0,           0,           0)); // 24 IGRANT
    vecs.push_back(mk(0, 1,0,0, 32'h500,32'h0,   0, 32'h0,        0,  1,0, 32'h500,  0,  1,1, 0,           0,           0)); // 25 nRST low
    vecs.push_back(mk(1, 1,0,0, 32'h500,32'h0,   0, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 26 reset took
    vecs.push_back(mk(1, 1,0,0, 32'h500,32'h0,   0, 32'h99,       1,  1,0, 32'h500,  0,  0,1, 32'h99,      0,           0)); // 27 I done
    vecs.push_back(mk(1, 0,0,0, 32'h0, 32'h0,    0, 32'h0,        0,  0,0, 32'h0,    0,  1,1, 0,           0,           0)); // 28 idle

    repeat (2) @(posedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i]);
      expQ.push_back(vecs[i]);
      #1;
      e = expQ.pop_front();
      chk("ramREN",   i, {31'b0, ramREN},  {31'b0, e.eRR});
      chk("ramWEN",   i, {31'b0, ramWEN},  {31'b0, e.eRW});
      chk("ramaddr",  i, ramaddr,          e.eRA);
      chk("ramstore", i, ramstore,         e.eRS);
      chk("iwait",    i, {31'b0, iwait},   {31'b0, e.eIW});
      chk("dwait",    i, {31'b0, dwait},   {31'b0, e.eDW});
      chk("iload",    i, iload,            e.eIL);
      chk("dload",    i, dload,            e.eDL);
      chk("starved",  i, {31'b0, starved}, {31'b0, e.eST});
      $display("vec %0d: ramREN=%b ramWEN=%b ramaddr=%h iwait=%b dwait=%b starved=%b",
               i, ramREN, ramWEN, ramaddr, iwait, dwait, starved);
    end

    // Starvation from a clean ARB, then reset while starved.
    firstStarved = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      nRST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
      iaddr = 32'h600; daddr = 32'h700; ram_ready = 1'b1; ramload = 32'h0;
      #1;
      if (starved) begin
        firstStarved = k;
        break;
      end
    end
    chk("starve_latency", 100, 32'(firstStarved), 32'd4);
    $display("seq starve: first starved cycle=%0d", firstStarved);

    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("starved_before_reset_edge", 101, {31'b0, starved}, 32'd1);
    chk("ramREN_before_reset_edge",  101, {31'b0, ramREN},  32'd1);
    @(negedge CLK);
    nRST = 1'b1; iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
    #1;
    chk("starved_after_reset", 102, {31'b0, starved}, 32'd0);
    chk("ramREN_after_reset",  102, {31'b0, ramREN},  32'd0);
    chk("iwait_after_reset",   102, {31'b0, iwait},   32'd1);
    $display("seq reset: starved=%b ramREN=%b iwait=%b", starved, ramREN, iwait);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
